wb_intercon_rr: RTL and testbench

//  Parametrised Wishbone shared-bus interconnect. Successor to the fixed 8x8 bus: N masters, M slaves.

---
 rtl/wb_intercon_rr_if.sv | 47 ++++
 rtl/wb_intercon_rr.sv | 167 ++++++++++++++++
 tb/tb_wb_intercon_rr.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_intercon_rr_if.sv
// Bundled Wishbone shared-bus signals between N masters, the interconnect and M slaves.
// Packed vectors carry one slice per master or per slave, lowest index in the low bits.
interface wb_intercon_rr_if #(
   parameter int NUM_M = 4,
   parameter int NUM_S = 8,
   parameter int ADR_W = 32,
   parameter int DAT_W = 32
);
   localparam int SEL_W = DAT_W / 8;

   logic [NUM_M-1:0]       m_cyc_i;
   logic [NUM_M-1:0]       m_stb_i;
   logic [NUM_M-1:0]       m_we_i;
   logic [NUM_M*ADR_W-1:0] m_adr_i;
   logic [NUM_M*DAT_W-1:0] m_dat_i;
   logic [NUM_M*SEL_W-1:0] m_sel_i;
   logic [DAT_W-1:0]       m_dat_o;
   logic [NUM_M-1:0]       m_ack_o;
   logic [NUM_M-1:0]       m_err_o;
   logic [NUM_M-1:0]       m_rty_o;
   logic [NUM_S-1:0]       s_cyc_o;
   logic [NUM_S-1:0]       s_stb_o;
   logic                   s_we_o;
   logic [ADR_W-1:0]       s_adr_o;
   logic [DAT_W-1:0]       s_dat_o;
   logic [SEL_W-1:0]       s_sel_o;
   logic [NUM_S*DAT_W-1:0] s_dat_i;
   logic [NUM_S-1:0]       s_ack_i;
   logic [NUM_S-1:0]       s_err_i;
   logic [NUM_S-1:0]       s_rty_i;

   // Interconnect view: it is addressed by the masters and drives the slaves.
   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
      output m_dat_o, m_ack_o, m_err_o, m_rty_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
   );

   // Environment view: masters and slaves attached around the interconnect.
   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      output s_dat_i, s_ack_i, s_err_i, s_rty_i,
      input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
   );
endinterface

// File: rtl/wb_intercon_rr.sv
// Wishbone shared-bus interconnect: registered round-robin arbitration, base/mask decode,
// registered error for unmapped accesses and a watchdog error for slaves that never answer.
module wb_intercon_rr #(
   parameter int                     NUM_M   = 4,
   parameter int                     NUM_S   = 8,
   parameter int                     ADR_W   = 32,
   parameter int                     DAT_W   = 32,
   parameter logic [NUM_S*ADR_W-1:0] S_BASE  = '0,
   parameter logic [NUM_S*ADR_W-1:0] S_MASK  = '0,
   parameter int                     TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset_n,
   wb_intercon_rr_if.slave  bus,
   output logic             fsm_state
);
   localparam int SEL_W = DAT_W / 8;
   localparam int GW    = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int SW    = (NUM_S > 1) ? $clog2(NUM_S) : 1;
   localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   // Handshake: a master requests with cyc&stb and holds them until it sees ack, err or rty
   // in a cycle; that cycle completes the beat. cyc held high keeps ownership of the bus.
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state, state_nx;
   logic [GW-1:0]     gnt, gnt_nx, last, last_nx, winner;
   logic              found, busy, hit, cyc_g, stb_g, term, wd_run;
   logic [SW-1:0]     sel;
   logic [ADR_W-1:0]  adr_g;
   logic              umap_err, wd_err;
   logic [WD_W-1:0]   wdog;

   logic [NUM_M-1:0]  ack_v, err_v, rty_v;
   logic [NUM_S-1:0]  s_cyc_v, s_stb_v;
   logic [DAT_W-1:0]  m_dat_v, s_dat_v;
   logic [ADR_W-1:0]  s_adr_v;
   logic [SEL_W-1:0]  s_sel_v;
   logic              s_we_v;

   assign fsm_state = state;
   assign busy      = (state == BUSY);
   assign cyc_g     = bus.m_cyc_i[gnt];
   assign stb_g     = bus.m_stb_i[gnt];
   assign adr_g     = bus.m_adr_i[int'(gnt)*ADR_W +: ADR_W];

   // First requester after the previous owner wins.
   always_comb begin
      found  = 1'b0;
      winner = last;
      for (int k = 1; k <= NUM_M; k++) begin
         if (!found && bus.m_cyc_i[(int'(last) + k) % NUM_M]) begin
            found  = 1'b1;
            winner = GW'((int'(last) + k) % NUM_M);
         end
      end
   end

   // Scan downward so that the lowest matching slave index is the one kept.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int i = NUM_S - 1; i >= 0; i--) begin
         if ((adr_g & S_MASK[i*ADR_W +: ADR_W]) == S_BASE[i*ADR_W +: ADR_W]) begin
            hit = 1'b1;
            sel = SW'(i);
         end
      end
   end

   assign term   = hit && (bus.s_ack_i[sel] || bus.s_err_i[sel] || bus.s_rty_i[sel]);
   assign wd_run = busy && cyc_g && stb_g && hit && !term;

   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      last_nx  = last;
      case (state)
         IDLE: begin
            if (found) begin
               state_nx = BUSY;
               gnt_nx   = winner;
               last_nx  = winner;
            end
         end
         BUSY: begin
            if (!cyc_g) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ack_v   = '0;
      err_v   = '0;
      rty_v   = '0;
      s_cyc_v = '0;
      s_stb_v = '0;
      m_dat_v = '0;
      s_we_v  = 1'b0;
      s_adr_v = '0;
      s_dat_v = '0;
      s_sel_v = '0;
      if (busy) begin
         s_we_v  = bus.m_we_i[gnt];
         s_adr_v = adr_g;
         s_dat_v = bus.m_dat_i[int'(gnt)*DAT_W +: DAT_W];
         s_sel_v = bus.m_sel_i[int'(gnt)*SEL_W +: SEL_W];
         if (hit) begin
            s_cyc_v[sel] = cyc_g;
            s_stb_v[sel] = stb_g;
            m_dat_v      = bus.s_dat_i[int'(sel)*DAT_W +: DAT_W];
            // A real slave response always beats a watchdog expiry landing in the same cycle.
            if (term) begin
               ack_v[gnt] = bus.s_ack_i[sel];
               err_v[gnt] = bus.s_err_i[sel];
               rty_v[gnt] = bus.s_rty_i[sel];
            end else if (wd_err) begin
               err_v[gnt] = 1'b1;
            end
         end else begin
            err_v[gnt] = umap_err;
         end
      end
   end

   assign bus.m_ack_o = ack_v;
   assign bus.m_err_o = err_v;
   assign bus.m_rty_o = rty_v;
   assign bus.m_dat_o = m_dat_v;
   assign bus.s_cyc_o = s_cyc_v;
   assign bus.s_stb_o = s_stb_v;
   assign bus.s_we_o  = s_we_v;
   assign bus.s_adr_o = s_adr_v;
   assign bus.s_dat_o = s_dat_v;
   assign bus.s_sel_o = s_sel_v;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         gnt      <= '0;
         last     <= GW'(NUM_M - 1);
         umap_err <= 1'b0;
         wdog     <= '0;
         wd_err   <= 1'b0;
      end else begin
         state    <= state_nx;
         gnt      <= gnt_nx;
         last     <= last_nx;
         // Toggles off after one cycle so a held stb errors every other cycle.
         umap_err <= busy && cyc_g && stb_g && !hit && !umap_err;
         if (TIMEOUT != 0 && wd_run) begin
            if (wdog == WD_LAST) begin
               wdog   <= '0;
               wd_err <= 1'b1;
            end else begin
               wdog   <= wdog + 1'b1;
               wd_err <= 1'b0;
            end
         end else begin
            wdog   <= '0;
            wd_err <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_wb_intercon_rr.sv
// Directed bench for wb_intercon_rr: 4 masters, 8 slaves at 256 MB windows, TIMEOUT=8.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns after that.
module tb_wb_intercon_rr;
   localparam int NUM_M = 4;
   localparam int NUM_S = 8;
   localparam logic [NUM_S*32-1:0] S_BASE = {32'h7000_0000, 32'h6000_0000, 32'h5000_0000,
      32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
   // Slave 6 uses a wider mask and shadows slave 7.
   localparam logic [NUM_S*32-1:0] S_MASK = {32'hF000_0000, 32'hE000_0000, {6{32'hF000_0000}}};

   logic clk;
   logic reset_n;
   logic fsm_state;
   int   checks   = 0;
   int   failures = 0;

   wb_intercon_rr_if #(.NUM_M(NUM_M), .NUM_S(NUM_S), .ADR_W(32), .DAT_W(32)) bus ();

   wb_intercon_rr #(
      .NUM_M(NUM_M), .NUM_S(NUM_S), .ADR_W(32), .DAT_W(32),
      .S_BASE(S_BASE), .S_MASK(S_MASK), .TIMEOUT(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus),
      .fsm_state(fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int k, input logic cyc, input logic stb, input logic [31:0] adr);
      bus.m_cyc_i[k]          = cyc;
      bus.m_stb_i[k]          = stb;
      bus.m_adr_i[k*32 +: 32] = adr;
   endtask

   task automatic set_w(input int k, input logic we, input logic [31:0] dat, input logic [3:0] sel);
      bus.m_we_i[k]          = we;
      bus.m_dat_i[k*32 +: 32] = dat;
      bus.m_sel_i[k*4 +: 4]   = sel;
   endtask

   initial begin
      reset_n     = 1'b0;
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.m_we_i  = '0;
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.m_sel_i = '0;
      bus.s_ack_i = '0;
      bus.s_err_i = '0;
      bus.s_rty_i = '0;
      for (int i = 0; i < NUM_S; i++)
         bus.s_dat_i[i*32 +: 32] = (i == 0) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", fsm_state, 0);
      check("rst_s_cyc", bus.s_cyc_o, 0);
      check("rst_m_ack", bus.m_ack_o, 0);
      check("rst_m_dat", bus.m_dat_o, 0);
      reset_n = 1'b1;

      // Single read from slave 0, ack two cycles after the grant
      step(); set_m(0, 1, 1, 32'h10); #1;
      check("t1_idle_s_cyc", bus.s_cyc_o, 0);
      step(); #1;
      check("t1_busy", fsm_state, 1);
      check("t1_s_cyc", bus.s_cyc_o, 8'h01);
      check("t1_s_stb", bus.s_stb_o, 8'h01);
      check("t1_s_adr", bus.s_adr_o, 32'h10);
      check("t1_no_ack_yet", bus.m_ack_o, 0);
      step();
      step(); bus.s_ack_i[0] = 1'b1; #1;
      check("t1_m_ack", bus.m_ack_o, 4'b0001);
      check("t1_m_dat", bus.m_dat_o, 32'hDEAD_BEEF);
      step(); bus.s_ack_i = '0; set_m(0, 0, 0, 0); #1;
      check("t1_ack_gone", bus.m_ack_o, 0);
      step(); #1;
      check("t1_idle", fsm_state, 0);

      // Round robin after reset: all four request, grants 0,1,2,3 then 0 again
      reset_n = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step();
      for (int k = 0; k < NUM_M; k++) set_m(k, 1, 1, 32'(k) << 28);
      for (int k = 0; k < NUM_M; k++) begin
         step(); #1;
         check("t2_grant_s_cyc", bus.s_cyc_o, 64'd1 << k);
         bus.s_ack_i[k] = 1'b1; #1;
         check("t2_grant_ack", bus.m_ack_o, 64'd1 << k);
         step(); bus.s_ack_i = '0; set_m(k, 0, 0, 0);
         if (k == NUM_M - 1) set_m(0, 1, 1, 32'h0000_0040);
         #1;
         check("t2_released", bus.s_cyc_o, 0);
         step(); #1;
         check("t2_dead_cycle", fsm_state, 0);
      end
      step(); #1;
      check("t2_m0_again", bus.s_cyc_o, 8'h01);
      bus.s_ack_i[0] = 1'b1;
      step(); bus.s_ack_i = '0; set_m(0, 0, 0, 0);
      step();

      // 4-beat write burst by m1 while m2 waits
      set_m(1, 1, 1, 32'h1000_0000);
      set_m(2, 1, 1, 32'h2000_0000);
      for (int b = 0; b < 4; b++) begin
         step();
         set_m(1, 1, 1, 32'h1000_0000 + 32'(4 * b));
         set_w(1, 1, 32'h1111_0000 + 32'(b), 4'hF);
         bus.s_ack_i[1] = 1'b1; #1;
         check("t3_burst_s_cyc", bus.s_cyc_o, 8'h02);
         check("t3_burst_ack", bus.m_ack_o, 4'b0010);
         check("t3_burst_adr", bus.s_adr_o, 32'h1000_0000 + 32'(4 * b));
         check("t3_burst_dat", bus.s_dat_o, 32'h1111_0000 + 32'(b));
      end
      check("t3_we_sel", {bus.s_we_o, bus.s_sel_o}, 5'b1_1111);
      step(); set_m(1, 0, 0, 0); set_w(1, 0, 0, 0); bus.s_ack_i = '0; #1;
      check("t3_m1_dropped", bus.s_cyc_o, 0);
      step(); #1;
      check("t3_dead_cycle", fsm_state, 0);
      step(); #1;
      check("t3_m2_granted", bus.s_cyc_o, 8'h04);
      bus.s_ack_i[2] = 1'b1; #1;
      check("t3_m2_ack", bus.m_ack_o, 4'b0100);
      check("t3_m2_dat", bus.m_dat_o, 32'hA000_0002);
      step(); bus.s_ack_i = '0; set_m(2, 0, 0, 0);
      step();

      // Unmapped access by m3: error one cycle after stb, then every other cycle
      set_m(3, 1, 1, 32'hF000_0000);
      step(); #1;
      check("t4_busy", fsm_state, 1);
      check("t4_no_s_stb", bus.s_stb_o, 0);
      check("t4_err_not_yet", bus.m_err_o, 0);
      step(); #1;
      check("t4_err", bus.m_err_o, 4'b1000);
      check("t4_no_s_stb2", bus.s_stb_o, 0);
      step(); #1;
      check("t4_err_cleared", bus.m_err_o, 0);
      step(); #1;
      check("t4_err_again", bus.m_err_o, 4'b1000);
      step(); set_m(3, 0, 0, 0); #1;
      check("t4_err_off", bus.m_err_o, 0);
      step();

      // Watchdog: slave 6 (shadowing slave 7) never answers; unselected err ignored
      set_m(0, 1, 1, 32'h7000_0010);
      bus.s_err_i[3] = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step(); #1;
         check("t5_s_cyc", bus.s_cyc_o, 8'h40);
         check("t5_wdog_err", bus.m_err_o, (c == 9) ? 4'b0001 : 4'b0000);
      end
      step(); set_m(0, 0, 0, 0); bus.s_err_i = '0;
      step();

      // Watchdog expiry cycle coincides with a slave ack: ack wins
      set_m(0, 1, 1, 32'h7000_0010);
      for (int c = 1; c <= 9; c++) begin
         step();
         if (c == 9) bus.s_ack_i[6] = 1'b1;
         #1;
         check("t5b_no_err", bus.m_err_o, 0);
         check("t5b_ack", bus.m_ack_o, (c == 9) ? 4'b0001 : 4'b0000);
      end
      step(); set_m(0, 0, 0, 0); bus.s_ack_i = '0;
      step();

      // Reset during a transfer, then m0 wins against everyone
      set_m(1, 1, 1, 32'h1000_0000);
      step(); #1;
      check("t6_m1_busy", bus.s_cyc_o, 8'h02);
      step(); reset_n = 1'b0; #1;
      check("t6_rst_state", fsm_state, 0);
      check("t6_rst_s_cyc", bus.s_cyc_o, 0);
      check("t6_rst_s_adr", bus.s_adr_o, 0);
      for (int k = 0; k < NUM_M; k++) set_m(k, 1, 1, 32'(k) << 28);
      step(); step();
      reset_n = 1'b1;
      step(); #1;
      check("t6_m0_wins", bus.s_cyc_o, 8'h01);
      for (int k = 0; k < NUM_M; k++) set_m(k, 0, 0, 0);
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
